// File: rtl/reg_bank_pkg.sv
// Shared constants and dump FSM encoding for the 32-entry register bank.
package reg_bank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int SP_RESET = 227;
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SCAN = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_bank_dump_fsm.sv
// Sequencer for the register dump: walks every index exactly once, then one DONE cycle.
module reg_bank_dump_fsm
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = reg_bank_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_d = DUMP_SCAN;
          cnt_d   = '0;
        end
      end
      DUMP_SCAN: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        dump_addr  = cnt_q;
        // Stop on an explicit compare so the counter never wraps inside a dump.
        if (cnt_q == LAST_IDX) state_d = DUMP_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Two-read / one-write register bank with write-first bypass and a background dump port.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = reg_bank_pkg::DATA_W,
  parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
  parameter int SP_RESET = reg_bank_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_valid,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] reset_val [NUM_REGS];

  logic [ADDR_W-1:0] rd_idx [2];
  logic [DATA_W-1:0] rd_val [2];
  logic [DATA_W-1:0] read_data_q [2];
  logic [DATA_W-1:0] read_data_d [2];
  logic              read_valid_q, read_valid_d;
  logic              wr_active;

  assign wr_active = reg_write && (write_reg != ZERO_IDX);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reset_val
      assign reset_val[gi] = (gi == REG_SP) ? DATA_W'(SP_RESET) : '0;
    end
  endgenerate

  always_comb begin
    regs_d = regs_q;
    if (wr_active) regs_d[write_reg] = write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= reset_val;
    else       regs_q <= regs_d;
  end

  assign rd_idx[0] = read_reg_1;
  assign rd_idx[1] = read_reg_2;

  // Each read port sees an in-flight write to its index (write-first).
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read_port
      always_comb begin
        rd_val[gi] = regs_q[rd_idx[gi]];
        if (rd_idx[gi] == ZERO_IDX)                  rd_val[gi] = '0;
        else if (wr_active && write_reg == rd_idx[gi]) rd_val[gi] = write_data;
        read_data_d[gi] = read_en ? rd_val[gi] : read_data_q[gi];
      end
    end
  endgenerate

  assign read_valid_d = read_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q[0] <= '0;
      read_data_q[1] <= '0;
      read_valid_q   <= 1'b0;
    end else begin
      read_data_q    <= read_data_d;
      read_valid_q   <= read_valid_d;
    end
  end

  assign read_data_1 = read_data_q[0];
  assign read_data_2 = read_data_q[1];
  assign read_valid  = read_valid_q;

  reg_bank_dump_fsm #(
    .ADDR_W (ADDR_W)
  ) u_dump_fsm (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr)
  );

  always_comb begin
    dump_data = '0;
    if (dump_valid) begin
      if (dump_addr == ZERO_IDX)                   dump_data = '0;
      else if (wr_active && write_reg == dump_addr) dump_data = write_data;
      else                                         dump_data = regs_q[dump_addr];
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed plus randomized check of reg_bank against a cycle-level behavioural model.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        read_en;
  logic [4:0]  read_reg_1, read_reg_2;
  logic [31:0] read_data_1, read_data_2;
  logic        read_valid;
  logic        dump_start;
  logic        dump_busy, dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk         (clk),
    .reset       (reset),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_en     (read_en),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .read_valid  (read_valid),
    .dump_start  (dump_start),
    .dump_busy   (dump_busy),
    .dump_valid  (dump_valid),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: architectural register contents plus dump position (-1 idle, 32 done).
  logic [31:0] m_regs [32];
  logic [31:0] e_rd1, e_rd2;
  logic        e_rv;
  int          dpos;
  logic        s_dv, s_busy;
  logic [4:0]  s_da;
  logic [31:0] s_dd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_read(input int idx);
    if (idx == 0) return 32'd0;
    if (reg_write && int'(write_reg) == idx) return write_data;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_regs[29] = 32'd227;
    e_rd1 = 32'd0;
    e_rd2 = 32'd0;
    e_rv  = 1'b0;
    dpos  = -1;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (read_en) begin
        e_rd1 = m_read(int'(read_reg_1));
        e_rd2 = m_read(int'(read_reg_2));
      end
      e_rv = read_en;
      if (dpos < 0) begin
        if (dump_start) dpos = 0;
      end else if (dpos == 32) begin
        dpos = -1;
      end else begin
        dpos++;
      end
      if (reg_write && write_reg != 5'd0) m_regs[write_reg] = write_data;
    end
  endtask

  task automatic idle();
    reset      = 1'b0;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'd0;
    read_en    = 1'b0;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    dump_start = 1'b0;
  endtask

  // Inputs are set by the caller just after a falling edge.
  task automatic cycle();
    logic act;
    #1;
    act = (dpos >= 0) && (dpos < 32);
    s_dv = dump_valid; s_busy = dump_busy; s_da = dump_addr; s_dd = dump_data;
    chk("dump_busy",  {31'd0, dump_busy},  {31'd0, act});
    chk("dump_valid", {31'd0, dump_valid}, {31'd0, act});
    chk("dump_addr",  {27'd0, dump_addr},  act ? 32'(dpos) : 32'd0);
    chk("dump_data",  dump_data,           act ? m_read(dpos) : 32'd0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("read_valid",  {31'd0, read_valid}, {31'd0, e_rv});
    chk("read_data_1", read_data_1, e_rd1);
    chk("read_data_2", read_data_2, e_rd2);
    $display("cyc %0d rst=%b we=%b wr=%0d wd=%08h re=%b r1=%0d r2=%0d -> rv=%b d1=%08h d2=%08h dv=%b da=%0d dd=%08h",
             cyc, reset, reg_write, write_reg, write_data, read_en, read_reg_1, read_reg_2,
             read_valid, read_data_1, read_data_2, s_dv, s_da, s_dd);
    cyc++;
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
    idle(); reg_write = 1'b1; write_reg = idx; write_data = val; cycle();
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b);
    idle(); read_en = 1'b1; read_reg_1 = a; read_reg_2 = b; cycle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read_valid", {31'd0, read_valid}, 32'd0);
    chk("rst_read_data_1", read_data_1, 32'd0);
    chk("rst_read_data_2", read_data_2, 32'd0);
    chk("rst_dump_busy", {31'd0, dump_busy}, 32'd0);
    chk("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_dump_addr", {27'd0, dump_addr}, 32'd0);
    chk("rst_dump_data", dump_data, 32'd0);

    // Stack pointer reset value and hard-wired zero.
    do_read(5'd29, 5'd0);
    chk("sp_reset", read_data_1, 32'd227);
    chk("zero_read", read_data_2, 32'd0);
    chk("sp_valid", {31'd0, read_valid}, 32'd1);
    idle(); cycle();
    chk("valid_drop", {31'd0, read_valid}, 32'd0);
    chk("hold_data_1", read_data_1, 32'd227);

    do_write(5'd0, 32'hDEADBEEF);
    do_read(5'd0, 5'd0);
    chk("zero_after_write", read_data_1, 32'd0);

    // Same-cycle write/read bypass.
    idle(); reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h40;
    read_en = 1'b1; read_reg_1 = 5'd31; read_reg_2 = 5'd29; cycle();
    chk("ra_bypass", read_data_1, 32'h40);
    chk("bypass_other_port", read_data_2, 32'd227);

    // Full dump of a known pattern.
    for (int k = 1; k < 32; k++) do_write(5'(k), 32'(k) * 32'h11);
    idle(); dump_start = 1'b1; cycle();
    for (int i = 0; i < 32; i++) begin
      idle(); cycle();
      chk("seq_valid", {31'd0, s_dv}, 32'd1);
      chk("seq_addr", {27'd0, s_da}, 32'(i));
      chk("seq_data", s_dd, 32'(i) * 32'h11);
    end
    idle(); cycle();
    chk("done_busy", {31'd0, s_busy}, 32'd0);
    chk("done_valid", {31'd0, s_dv}, 32'd0);
    idle(); cycle();

    // Write landing on the index currently being dumped.
    idle(); dump_start = 1'b1; cycle();
    for (int i = 0; i < 20; i++) begin idle(); cycle(); end
    do_write(5'd20, 32'h1234);
    chk("dump_bypass_addr", {27'd0, s_da}, 32'd20);
    chk("dump_bypass_data", s_dd, 32'h1234);
    for (int i = 0; i < 14; i++) begin idle(); cycle(); end

    // Ignored restart while busy, then reset aborting a dump mid-scan.
    idle(); dump_start = 1'b1; cycle();
    for (int i = 0; i < 10; i++) begin idle(); dump_start = (i == 4); cycle(); end
    idle(); reset = 1'b1; cycle();
    chk("abort_addr_seen", {27'd0, s_da}, 32'd10);
    idle(); cycle();
    chk("abort_valid", {31'd0, s_dv}, 32'd0);
    chk("abort_busy", {31'd0, s_busy}, 32'd0);
    do_read(5'd29, 5'd5);
    chk("abort_sp", read_data_1, 32'd227);
    chk("abort_r5", read_data_2, 32'd0);

    // Randomized traffic, including dumps, bypass collisions and occasional reset.
    for (int n = 0; n < 400; n++) begin
      idle();
      reg_write  = ($urandom_range(0, 1) == 1);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_en    = ($urandom_range(0, 2) != 0);
      read_reg_1 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg_2 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      dump_start = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 120) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, 32, register and data width.
REQ-002 Parameter ADDR_W, 5, register index width (32 registers).
REQ-003 Parameter SP_RESET, 227, reset value of register 29 (stack pointer).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 reg_write  in  1  write enable for write port.
REQ-007 write_reg  in  ADDR_W  write index, driven by the write-register select mux (rt, 29, 31, rd).
REQ-008 write_data  in  DATA_W  write value.
REQ-009 read_en  in  1  read request, captures both read indices.
REQ-010 read_reg_1 / read_reg_2  in  ADDR_W  read indices (rs, rt).
REQ-011 read_data_1 / read_data_2  out  DATA_W  registered read values.
REQ-012 read_valid  out  1  read_data_* valid this cycle.
REQ-013 dump_start  in  1  request sequential dump of all registers.
REQ-014 dump_busy  out  1  dump in progress.
REQ-015 dump_valid  out  1  dump_addr/dump_data valid this cycle.
REQ-016 dump_addr  out  ADDR_W  index being dumped.
REQ-017 dump_data  out  DATA_W  value being dumped.

Function
REQ-018 Register 0 SHALL read 0 always; writes to index 0 SHALL be discarded.
REQ-019 When reg_write=1 and write_reg!=0, register[write_reg] SHALL take write_data at the edge.
REQ-020 Read latency SHALL be 1 cycle: read_en at edge N -> read_data_* and read_valid=1 after edge N; read_valid=0 otherwise; read_data_* hold last value when read_valid=0.
REQ-021 Same-cycle write and read of same nonzero index SHALL return write_data (write-first bypass), per port independently.
REQ-022 Dump FSM states: IDLE, SCAN, DONE.
REQ-023 IDLE -> SCAN on dump_start=1; dump counter cleared to 0.
REQ-024 SCAN: each cycle dump_valid=1, dump_addr=counter, dump_data=register[counter] (bypass per REQ-021 applies); counter increments by 1.
REQ-025 SCAN -> DONE after counter=31 is presented; no wrap to 0 within a dump.
REQ-026 DONE: dump_valid=0, dump_busy=0, returns to IDLE next cycle.
REQ-027 dump_busy=1 in SCAN only; dump_start while busy SHALL be ignored.
REQ-028 Reads and writes SHALL proceed unaffected during SCAN; a dump never stalls the datapath.
REQ-029 Index arithmetic unsigned, ADDR_W bits; counter ADDR_W+0 bits with explicit last-index compare.

Reset
REQ-030 reset SHALL set all registers to 0 except register 29 = SP_RESET.
REQ-031 reset SHALL set read_data_*=0, read_valid=0, dump_valid=0, dump_busy=0, dump_addr=0, dump_data=0, FSM=IDLE.
REQ-032 reset SHALL take priority over reg_write, read_en and dump_start in the same cycle, and SHALL abort a dump mid-SCAN.

Structure
REQ-033 Shared package SHALL hold DATA_W, ADDR_W, SP_RESET, REG_ZERO=0, REG_SP=29, REG_RA=31 and the dump FSM state encoding.
REQ-034 One sub-module, reg_bank_dump_fsm (state, counter, dump_* control), SHALL be instantiated; storage and read ports remain in reg_bank.

Verification
REQ-035 Reset, then read_en with read_reg_1=29, read_reg_2=0 -> next cycle read_data_1=227, read_data_2=0, read_valid=1.
REQ-036 Write reg 0 with 0xDEADBEEF, then read 0 -> 0.
REQ-037 Same cycle: write reg 31=0x00000040, read_en read_reg_1=31 -> next cycle read_data_1=0x00000040.
REQ-038 Write reg k = k*0x11 for k=1..31, dump_start -> 32 consecutive dump_valid cycles, addr 0..31, data 0 then k*0x11 (29 overwritten), then dump_busy=0.
REQ-039 dump_start at SCAN addr 10, then reset -> next cycle dump_valid=0, dump_busy=0, reg 29=227, reg 5=0.
REQ-040 During SCAN, write reg 20=0x1234 when dump_addr=20 -> dump_data=0x1234.
